// File: rtl/pcie_mmio_pkg.sv
// Shared definitions for the PCIe MMIO AXI4-Lite responder: register map,
// default ID word, AXI response codes and FSM state encodings.
package pcie_mmio_pkg;

    localparam int unsigned OFF_ID       = 32'h00;
    localparam int unsigned OFF_SCRATCH  = 32'h04;
    localparam int unsigned OFF_CONTROL  = 32'h08;
    localparam int unsigned OFF_STATUS   = 32'h0C;
    localparam int unsigned OFF_DOORBELL = 32'h10;
    localparam int unsigned OFF_CYCLES   = 32'h14;
    localparam int unsigned OFF_GEN      = 32'h18;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hAC0A_0001;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/pcie_mmio_responder.sv
// AXI4-Lite completer exposing a small control/status register file to the host.
// Optional build macro MMIO_DECODE_ERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module pcie_mmio_responder
    import pcie_mmio_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter int          REG_COUNT  = 16,
    parameter logic [31:0] ID_VALUE   = ID_VALUE_DEFAULT
) (
    input  logic                  system_clock,
    input  logic                  system_reset_n,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [31:0]           control,
    input  logic [31:0]           status,
    output logic                  doorbell
);

    localparam int IW = ADDR_WIDTH - 2;
    localparam int SW = $clog2(REG_COUNT);

    localparam logic [IW-1:0] IX_ID       = IW'(OFF_ID >> 2);
    localparam logic [IW-1:0] IX_SCRATCH  = IW'(OFF_SCRATCH >> 2);
    localparam logic [IW-1:0] IX_CONTROL  = IW'(OFF_CONTROL >> 2);
    localparam logic [IW-1:0] IX_STATUS   = IW'(OFF_STATUS >> 2);
    localparam logic [IW-1:0] IX_DOORBELL = IW'(OFF_DOORBELL >> 2);
    localparam logic [IW-1:0] IX_CYCLES   = IW'(OFF_CYCLES >> 2);
    localparam logic [IW-1:0] IX_GEN      = IW'(OFF_GEN >> 2);
    localparam logic [IW-1:0] IX_LIMIT    = IW'(REG_COUNT);

`ifdef MMIO_DECODE_ERR_EN
    localparam axi_resp_t DECODE_RESP = RESP_SLVERR;
`else
    localparam axi_resp_t DECODE_RESP = RESP_OKAY;
`endif

    wr_state_t       w_state, w_next;
    rd_state_t       r_state, r_next;
    logic            aw_got, w_got;
    logic [IW-1:0]   aw_idx;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    axi_resp_t       bresp_q, rresp_q;
    logic [31:0]     rdata_q;
    logic [31:0]     regs [REG_COUNT];
    logic [31:0]     status_q;
    logic [31:0]     cycles;
    logic [31:0]     rd_word;
    logic [IW-1:0]   ar_idx;
    logic            aw_hs, w_hs, ar_hs;
    logic            aw_hit, ar_hit, aw_writable;

    wire unused_addr_lsb = ^{s_awaddr[1:0], s_araddr[1:0]};

    assign ar_idx      = s_araddr[ADDR_WIDTH-1:2];
    assign aw_hit      = aw_idx < IX_LIMIT;
    assign ar_hit      = ar_idx < IX_LIMIT;
    assign aw_writable = aw_hit && (aw_idx == IX_SCRATCH || aw_idx == IX_CONTROL || aw_idx >= IX_GEN);

    assign s_awready = (w_state == W_IDLE) && !aw_got;
    assign s_wready  = (w_state == W_IDLE) && !w_got;
    assign s_bvalid  = (w_state == W_RESP);
    assign s_bresp   = bresp_q;
    assign s_arready = (r_state == R_IDLE);
    assign s_rvalid  = (r_state == R_RESP);
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign ar_hs = s_arvalid && s_arready;

    assign control  = regs[IX_CONTROL[SW-1:0]];
    assign doorbell = (w_state == W_COMMIT) && (aw_idx == IX_DOORBELL) && (|wstrb_q);

    always_ff @(posedge system_clock) begin
        if (!system_reset_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // AW and W may arrive in either order; commit once both halves are held.
    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:   if ((aw_got || aw_hs) && (w_got || w_hs)) w_next = W_COMMIT;
            W_COMMIT: w_next = W_RESP;
            W_RESP:   if (s_bready) w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (s_arvalid) r_next = R_RESP;
            R_RESP:  if (s_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        if (ar_hit) begin
            if (ar_idx == IX_ID)            rd_word = ID_VALUE;
            else if (ar_idx == IX_STATUS)   rd_word = status_q;
            else if (ar_idx == IX_DOORBELL) rd_word = '0;
            else if (ar_idx == IX_CYCLES)   rd_word = cycles;
            else                            rd_word = regs[ar_idx[SW-1:0]];
        end
    end

    always_ff @(posedge system_clock) begin
        if (!system_reset_n) begin
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            aw_idx   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
            status_q <= '0;
            cycles   <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            cycles   <= cycles + 32'd1;
            status_q <= status;
            if (aw_hs) begin
                aw_got <= 1'b1;
                aw_idx <= s_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_got   <= 1'b1;
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end
            // Register update lands at the end of the commit cycle, so a read
            // captured during commit still sees the old contents.
            if (w_state == W_COMMIT) begin
                aw_got  <= 1'b0;
                w_got   <= 1'b0;
                bresp_q <= aw_hit ? RESP_OKAY : DECODE_RESP;
                if (aw_writable) begin
                    for (int b = 0; b < 4; b++)
                        if (wstrb_q[b]) regs[aw_idx[SW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
            if (ar_hs) begin
                rdata_q <= rd_word;
                rresp_q <= ar_hit ? RESP_OKAY : DECODE_RESP;
            end
        end
    end

endmodule
